// File: rtl/input_timer_periph.sv
`default_nettype none
// ============================================================================
// input_timer_periph : PS/2 scan-code receiver, NES/SNES pad poller and
//                      one-shot millisecond OS timer with interrupt pulse.
// Revision 1.0
// ============================================================================
module input_timer_periph #(
  parameter int unsigned NES_HALF   = 150,
  parameter int unsigned NES_POLL   = 416667,
  parameter int unsigned TIMER_TICK = 25000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_en,
  input  logic        ps2d,
  input  logic        ps2c,
  output logic        rx_done_tick,
  output logic [7:0]  rx_data,
  output logic        nesc,
  output logic        nesl,
  input  logic        nesd,
  output logic [15:0] nesState,
  input  logic [31:0] timerValue,
  input  logic        setValue,
  input  logic        trigger,
  output logic        interrupt
);

  localparam int PH_W    = $clog2(2 * NES_HALF);
  localparam int POLL_W  = (NES_POLL > 1) ? $clog2(NES_POLL) : 1;
  localparam int PRESC_W = (TIMER_TICK > 1) ? $clog2(TIMER_TICK) : 1;

  localparam logic [PH_W-1:0]    PH_HALF    = PH_W'(NES_HALF);
  localparam logic [PH_W-1:0]    PH_SAMPLE  = PH_W'(NES_HALF - 1);
  localparam logic [PH_W-1:0]    PH_LAST    = PH_W'(2 * NES_HALF - 1);
  localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(NES_POLL - 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TIMER_TICK - 1);
  localparam logic [4:0]         SLOT_LAST  = 5'd16;

  // --------------------------------------------------------------------------
  // PS/2 receiver
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    PS2_IDLE = 2'd0,
    PS2_DPS  = 2'd1,
    PS2_LOAD = 2'd2
  } ps2_state_e;

  ps2_state_e  ps2_state_q, ps2_state_d;
  logic [7:0]  filt_q, filt_d;
  logic        fval_q, fval_d;
  logic        ps2_strobe;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [10:0] shreg_q, shreg_d;
  logic        rx_done_q, rx_done_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        unused_start_bit;

  // The start bit falls out of the shift register and is never inspected.
  assign unused_start_bit = shreg_q[0];

  always_comb begin
    filt_d = {ps2c, filt_q[7:1]};
    if (filt_d == 8'hFF) begin
      fval_d = 1'b1;
    end else if (filt_d == 8'h00) begin
      fval_d = 1'b0;
    end else begin
      fval_d = fval_q;
    end
    ps2_strobe = fval_q & ~fval_d;

    ps2_state_d = ps2_state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rx_done_d   = 1'b0;
    rx_data_d   = rx_data_q;

    case (ps2_state_q)
      PS2_IDLE: begin
        if (ps2_strobe && rx_en) begin
          shreg_d     = {ps2d, shreg_q[10:1]};
          bit_cnt_d   = 4'd9;
          ps2_state_d = PS2_DPS;
        end
      end
      PS2_DPS: begin
        if (ps2_strobe) begin
          shreg_d = {ps2d, shreg_q[10:1]};
          if (bit_cnt_q == 4'd0) begin
            // Pulse is registered so it is visible during the LOAD cycle.
            ps2_state_d = PS2_LOAD;
            rx_done_d   = 1'b1;
            rx_data_d   = shreg_d[8:1];
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end
      end
      PS2_LOAD: begin
        ps2_state_d = PS2_IDLE;
      end
      default: begin
        ps2_state_d = PS2_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2_state_q <= PS2_IDLE;
      filt_q      <= 8'h00;
      fval_q      <= 1'b0;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 11'd0;
      rx_done_q   <= 1'b0;
      rx_data_q   <= 8'h00;
    end else begin
      ps2_state_q <= ps2_state_d;
      filt_q      <= filt_d;
      fval_q      <= fval_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rx_done_q   <= rx_done_d;
      rx_data_q   <= rx_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // NES/SNES pad poller: slot 0 is the latch pulse, slots 1..16 carry bits 0..15
  // --------------------------------------------------------------------------
  logic [POLL_W-1:0] poll_q, poll_d;
  logic              pad_active_q, pad_active_d;
  logic [4:0]        slot_q, slot_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [15:0]       shadow_q, shadow_d;
  logic [15:0]       nes_state_q, nes_state_d;
  logic              nesc_q, nesc_d;
  logic              nesl_q, nesl_d;
  logic [3:0]        bit_idx;

  assign bit_idx = slot_q[3:0] - 4'd1;

  always_comb begin
    poll_d       = (poll_q == POLL_LAST) ? '0 : poll_q + POLL_W'(1);
    pad_active_d = pad_active_q;
    slot_d       = slot_q;
    ph_d         = ph_q;
    shadow_d     = shadow_q;
    nes_state_d  = nes_state_q;

    if (!pad_active_q) begin
      if (poll_q == '0) begin
        pad_active_d = 1'b1;
        slot_d       = 5'd0;
        ph_d         = '0;
      end
    end else begin
      if ((slot_q != 5'd0) && (ph_q == PH_SAMPLE)) begin
        shadow_d[bit_idx] = ~nesd;
      end
      if (ph_q == PH_LAST) begin
        ph_d = '0;
        if (slot_q == SLOT_LAST) begin
          pad_active_d = 1'b0;
          slot_d       = 5'd0;
          nes_state_d  = shadow_q;
        end else begin
          slot_d = slot_q + 5'd1;
        end
      end else begin
        ph_d = ph_q + PH_W'(1);
      end
    end

    // Pin levels follow the next sequencer state so they stay registered.
    nesl_d = pad_active_d && (slot_d == 5'd0);
    nesc_d = !(pad_active_d && (slot_d != 5'd0) && (ph_d < PH_HALF));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      poll_q       <= '0;
      pad_active_q <= 1'b0;
      slot_q       <= 5'd0;
      ph_q         <= '0;
      shadow_q     <= 16'h0000;
      nes_state_q  <= 16'h0000;
      nesc_q       <= 1'b1;
      nesl_q       <= 1'b0;
    end else begin
      poll_q       <= poll_d;
      pad_active_q <= pad_active_d;
      slot_q       <= slot_d;
      ph_q         <= ph_d;
      shadow_q     <= shadow_d;
      nes_state_q  <= nes_state_d;
      nesc_q       <= nesc_d;
      nesl_q       <= nesl_d;
    end
  end

  // --------------------------------------------------------------------------
  // One-shot OS timer
  // --------------------------------------------------------------------------
  logic [31:0]        period_q, period_d;
  logic [31:0]        count_q, count_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               running_q, running_d;
  logic               irq_q, irq_d;
  logic [31:0]        load_val;
  logic [31:0]        cnt_base;
  logic [PRESC_W-1:0] presc_base;

  always_comb begin
    period_d = setValue ? timerValue : period_q;
    load_val = (period_d == 32'd0) ? 32'd1 : period_d;

    // The trigger cycle itself is prescaler cycle 0 of the first tick.
    cnt_base   = trigger ? load_val : count_q;
    presc_base = trigger ? '0 : presc_q;

    count_d   = count_q;
    presc_d   = presc_q;
    running_d = running_q;
    irq_d     = 1'b0;

    if (trigger || running_q) begin
      running_d = 1'b1;
      if (presc_base == PRESC_LAST) begin
        presc_d = '0;
        count_d = (cnt_base == 32'd0) ? 32'd0 : cnt_base - 32'd1;
        if (cnt_base <= 32'd1) begin
          running_d = 1'b0;
          irq_d     = 1'b1;
        end
      end else begin
        presc_d = presc_base + PRESC_W'(1);
        count_d = cnt_base;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_q  <= 32'd0;
      count_q   <= 32'd0;
      presc_q   <= '0;
      running_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      period_q  <= period_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      irq_q     <= irq_d;
    end
  end

  assign rx_done_tick = rx_done_q;
  assign rx_data      = rx_data_q;
  assign nesc         = nesc_q;
  assign nesl         = nesl_q;
  assign nesState     = nes_state_q;
  assign interrupt    = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_input_timer_periph.sv
`default_nettype none
// tb_input_timer_periph : randomized self-checking bench for input_timer_periph.
module tb_input_timer_periph;

  localparam int NES_HALF  = 3;
  localparam int NES_POLL  = 200;
  localparam int TICK      = 10;
  localparam int FRAME_LEN = 2 * NES_HALF * 17;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_en = 1'b0;
  logic        ps2d = 1'b1;
  logic        ps2c = 1'b1;
  logic        nesd = 1'b1;
  logic        setValue = 1'b0;
  logic        trigger = 1'b0;
  logic [31:0] timerValue = 32'd0;
  logic        rx_done_tick, nesc, nesl, interrupt;
  logic [7:0]  rx_data;
  logic [15:0] nesState;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int irq_cycles[$];
  int rx_cycles[$];
  logic [15:0] btn = 16'h0000;
  int          nes_idx = 16;
  logic [15:0] pad_exp = 16'h0000;
  logic [7:0]  rx_exp = 8'h00;

  input_timer_periph #(
    .NES_HALF  (NES_HALF),
    .NES_POLL  (NES_POLL),
    .TIMER_TICK(TICK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_en       (rx_en),
    .ps2d        (ps2d),
    .ps2c        (ps2c),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .nesc        (nesc),
    .nesl        (nesl),
    .nesd        (nesd),
    .nesState    (nesState),
    .timerValue  (timerValue),
    .setValue    (setValue),
    .trigger     (trigger),
    .interrupt   (interrupt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle of every interrupt / rx_done_tick high sample.
  always @(negedge clk) begin
    if (interrupt === 1'b1) irq_cycles.push_back(cyc);
    if (rx_done_tick === 1'b1) rx_cycles.push_back(cyc);
  end

  // Pad model: a parallel-load shift register, active-low data, shifts on nesc rise.
  always @(posedge nesl or posedge nesc) begin
    #2;
    if (nesl) nes_idx = 0;
    else if (nes_idx < 16) nes_idx = nes_idx + 1;
    nesd = (nes_idx < 16) ? ~btn[nes_idx] : 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic ps2_send(input logic [7:0] data, input logic en, input int nbits, output int stop_fall);
    logic [10:0] fr;
    fr = {1'b1, ~^data, data, 1'b0};
    rx_en = en;
    stop_fall = -1;
    for (int i = 0; i < nbits; i++) begin
      ps2d = fr[i];
      repeat (20) @(negedge clk);
      ps2c = 1'b0;
      stop_fall = cyc;
      repeat (20) @(negedge clk);
      ps2c = 1'b1;
    end
    repeat (30) @(negedge clk);
    rx_en = 1'b0;
  endtask

  task automatic timer_load(input logic [31:0] v);
    timerValue = v;
    setValue = 1'b1;
    @(negedge clk);
    setValue = 1'b0;
  endtask

  task automatic timer_run(input logic [31:0] per, input int retrig);
    int n0, t0, expc, eff, got;
    timer_load(per);
    eff = (per == 32'd0) ? 1 : int'(per);
    n0 = irq_cycles.size();
    trigger = 1'b1; t0 = cyc; @(negedge clk); trigger = 1'b0;
    expc = t0 + eff * TICK;
    if (retrig > 0 && retrig < eff * TICK) begin
      while (cyc < t0 + retrig) @(negedge clk);
      trigger = 1'b1; t0 = cyc; @(negedge clk); trigger = 1'b0;
      expc = t0 + eff * TICK;
    end
    while (cyc < expc + 3 * TICK) @(negedge clk);
    got = (irq_cycles.size() > n0) ? irq_cycles[n0] : -1;
    total++;
    if (irq_cycles.size() - n0 != 1) begin
      bad++;
      $display("FAIL timer_pulse_count per=%0d retrig=%0d: got %0d pulses want 1", per, retrig, irq_cycles.size() - n0);
    end
    total++;
    if (got != expc) begin
      bad++;
      $display("FAIL timer_pulse_cycle per=%0d retrig=%0d: got cycle %0d want %0d", per, retrig, got, expc);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (rx_done_tick !== 1'b0) begin bad++; $display("FAIL reset_rx_done_tick: got %b want 0", rx_done_tick); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    total++; if (nesc !== 1'b1) begin bad++; $display("FAIL reset_nesc: got %b want 1", nesc); end
    total++; if (nesl !== 1'b0) begin bad++; $display("FAIL reset_nesl: got %b want 0", nesl); end
    total++; if (nesState !== 16'h0000) begin bad++; $display("FAIL reset_nesState: got %h want 0000", nesState); end
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL reset_interrupt: got %b want 0", interrupt); end
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic check_frame(input logic [7:0] data, input logic en, input string name);
    int p0, sf, got;
    p0 = rx_cycles.size();
    ps2_send(data, en, 11, sf);
    if (en) rx_exp = data;
    total++;
    if (rx_cycles.size() - p0 != (en ? 1 : 0)) begin
      bad++;
      $display("FAIL %s_pulses: got %0d want %0d", name, rx_cycles.size() - p0, en ? 1 : 0);
    end
    total++;
    if (rx_data !== rx_exp) begin
      bad++;
      $display("FAIL %s_data: got %h want %h", name, rx_data, rx_exp);
    end
    if (en) begin
      got = (rx_cycles.size() > p0) ? rx_cycles[p0] : -1;
      total++;
      if (got < sf + 8 || got > sf + 10) begin
        bad++;
        $display("FAIL %s_latency: pulse at cycle %0d want %0d..%0d", name, got, sf + 8, sf + 10);
      end
    end
  endtask

  task automatic test_ps2_frame();
    check_frame(8'h1C, 1'b1, "ps2_1c");
  endtask

  task automatic test_ps2_rx_en();
    logic [7:0] d;
    d = 8'(rx_exp ^ 8'(1 + $urandom_range(0, 254)));
    check_frame(d, 1'b0, "ps2_disabled");
    check_frame(d, 1'b1, "ps2_enabled");
  endtask

  task automatic test_ps2_random();
    for (int i = 0; i < 3; i++) check_frame(8'($urandom), 1'b1, "ps2_rand");
  endtask

  task automatic pad_frame(input logic [15:0] val);
    logic prev, prev_c, ok;
    int width, rises;
    ok = 1'b0;
    for (int i = 0; i < 3 * NES_POLL && !ok; i++) begin
      prev = nesl; @(negedge clk); if (!prev && nesl) ok = 1'b1;
    end
    if (ok) begin
      repeat (FRAME_LEN + 8) @(negedge clk);
      btn = val;
      ok = 1'b0;
      for (int i = 0; i < 3 * NES_POLL && !ok; i++) begin
        prev = nesl; @(negedge clk); if (!prev && nesl) ok = 1'b1;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL pad_sync: got no nesl rise want one within %0d cycles", 3 * NES_POLL);
    end else begin
      width = 1; rises = 0; prev_c = nesc;
      for (int k = 1; k <= FRAME_LEN; k++) begin
        @(negedge clk);
        if (nesl) width++;
        if (!prev_c && nesc) rises++;
        prev_c = nesc;
        if (k == FRAME_LEN - 1) begin
          total++;
          if (nesState !== pad_exp) begin bad++; $display("FAIL pad_early: got %h want %h", nesState, pad_exp); end
        end
        if (k == FRAME_LEN) begin
          total++;
          if (nesState !== val) begin bad++; $display("FAIL pad_state: got %h want %h", nesState, val); end
        end
      end
      total++;
      if (width != 2 * NES_HALF) begin bad++; $display("FAIL pad_nesl_width: got %0d want %0d", width, 2 * NES_HALF); end
      total++;
      if (rises != 16) begin bad++; $display("FAIL pad_nesc_rises: got %0d want 16", rises); end
      pad_exp = val;
    end
  endtask

  task automatic test_pad_pattern();
    pad_frame(16'h0009);
  endtask

  task automatic test_pad_random();
    for (int i = 0; i < 2; i++) pad_frame(16'($urandom));
  endtask

  task automatic test_timer_basic();
    timer_run(32'd5, 0);
  endtask

  task automatic test_timer_retrig();
    timer_run(32'd5, 30);
    timer_run(32'd0, 0);
  endtask

  task automatic test_timer_set_while_running();
    int n0, t0, got;
    timer_load(32'd5);
    n0 = irq_cycles.size();
    trigger = 1'b1; t0 = cyc; @(negedge clk); trigger = 1'b0;
    while (cyc < t0 + 10) @(negedge clk);
    timer_load(32'd1);
    while (cyc < t0 + 5 * TICK + 20) @(negedge clk);
    got = (irq_cycles.size() > n0) ? irq_cycles[n0] : -1;
    total++;
    if (irq_cycles.size() - n0 != 1 || got != t0 + 5 * TICK) begin
      bad++;
      $display("FAIL timer_set_running: got %0d pulses first at %0d want 1 at %0d", irq_cycles.size() - n0, got, t0 + 5 * TICK);
    end
    n0 = irq_cycles.size();
    trigger = 1'b1; t0 = cyc; @(negedge clk); trigger = 1'b0;
    while (cyc < t0 + TICK + 20) @(negedge clk);
    got = (irq_cycles.size() > n0) ? irq_cycles[n0] : -1;
    total++;
    if (irq_cycles.size() - n0 != 1 || got != t0 + TICK) begin
      bad++;
      $display("FAIL timer_new_period: got %0d pulses first at %0d want 1 at %0d", irq_cycles.size() - n0, got, t0 + TICK);
    end
    n0 = irq_cycles.size();
    timerValue = 32'd3; setValue = 1'b1; trigger = 1'b1; t0 = cyc;
    @(negedge clk);
    setValue = 1'b0; trigger = 1'b0;
    while (cyc < t0 + 3 * TICK + 20) @(negedge clk);
    got = (irq_cycles.size() > n0) ? irq_cycles[n0] : -1;
    total++;
    if (irq_cycles.size() - n0 != 1 || got != t0 + 3 * TICK) begin
      bad++;
      $display("FAIL timer_set_and_trigger: got %0d pulses first at %0d want 1 at %0d", irq_cycles.size() - n0, got, t0 + 3 * TICK);
    end
  endtask

  task automatic test_timer_random();
    int per, eff, rt;
    for (int i = 0; i < 5; i++) begin
      per = $urandom_range(0, 6);
      eff = (per == 0) ? 1 : per;
      rt = ($urandom_range(0, 1) == 1) ? $urandom_range(1, eff * TICK - 1) : 0;
      timer_run(32'(per), rt);
    end
  endtask

  task automatic test_reset_midop();
    int n0, p0, sf;
    timer_load(32'd4);
    n0 = irq_cycles.size();
    trigger = 1'b1; @(negedge clk); trigger = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL midop_interrupt: got %b want 0", interrupt); end
    total++; if (nesc !== 1'b1 || nesl !== 1'b0) begin bad++; $display("FAIL midop_pad_pins: got nesc=%b nesl=%b want 1 0", nesc, nesl); end
    total++; if (nesState !== 16'h0000) begin bad++; $display("FAIL midop_nesState: got %h want 0000", nesState); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL midop_rx_data: got %h want 00", rx_data); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rx_exp = 8'h00;
    repeat (60) @(negedge clk);
    total++;
    if (irq_cycles.size() != n0) begin bad++; $display("FAIL midop_no_irq: got %0d pulses want 0", irq_cycles.size() - n0); end

    p0 = rx_cycles.size();
    ps2_send(8'hA5, 1'b1, 5, sf);
    reset = 1'b0;
    @(negedge clk);
    total++; if (rx_done_tick !== 1'b0 || rx_data !== 8'h00) begin bad++; $display("FAIL midframe_reset: got tick=%b data=%h want 0 00", rx_done_tick, rx_data); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    total++;
    if (rx_cycles.size() != p0 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL midframe_no_pulse: got %0d pulses data=%h want 0 00", rx_cycles.size() - p0, rx_data);
    end
    check_frame(8'h5A, 1'b1, "ps2_after_reset");
  endtask

  initial begin
    test_reset();
    test_ps2_frame();
    test_ps2_rx_en();
    test_ps2_random();
    test_pad_pattern();
    test_pad_random();
    test_timer_basic();
    test_timer_retrig();
    test_timer_set_while_running();
    test_timer_random();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
